shift_sub_divider: RTL
======================

Name: shift_sub_divider

Overview:
- Unsigned sequential restoring divider; the inverse datapath of the shift-add multiplier.
- Computes quotient and remainder of dividend / divisor, one quotient bit per clock.
- Uses a loadable down-counter with zero flag for iteration control.
- Sits beside the multiplier in the arithmetic unit, with the same start/busy/done handshake.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend, captured at accepted start
- divisor  input  WIDTH  unsigned divisor, captured at accepted start
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse; results valid this cycle and held afterwards
- quotient  output  WIDTH  result quotient
- remainder  output  WIDTH  result remainder
- div_by_zero  output  1  set with done when captured divisor == 0; held with results

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal registers=0.
- FSM states: IDLE, CALC, DONE.
- IDLE, start=1, divisor!=0:
  - Load Q=dividend, R=0 (WIDTH+1 bits), D=divisor, counter=WIDTH.
  - Clear div_by_zero. Next state CALC.
- IDLE, start=1, divisor==0:
  - Load Q=all ones, R=dividend, set div_by_zero. Next state DONE (no CALC).
- IDLE, start=0: hold state; outputs keep last results.
- CALC, each cycle:
  - {R,Q} shifted left 1.
  - trial = R_shifted - {1'b0,D}.
  - If trial MSB==0: R=trial, Q[0]=1. Else: R=R_shifted, Q[0]=0.
  - Counter decrements by 1.
  - When counter==1 at the edge, the final iteration executes and the next state is DONE.
- DONE: done=1 for exactly one cycle. quotient=Q, remainder=R[WIDTH-1:0]. Next state IDLE.
- Latency:
  - Normal: done high in cycle WIDTH+1 after the accepted start edge.
  - Divide-by-zero: done high in cycle 1 after the accepted start edge.
- start while busy: ignored; no restart, no queuing. Operand changes while busy have no effect.
- start high in the DONE cycle: ignored. A new start is accepted in IDLE the following cycle; minimum issue interval WIDTH+2 cycles.
- Output update rule: quotient/remainder/div_by_zero are driven from Q/R/flag.
  - They change only in CALC/DONE, or on a divide-by-zero load.
  - Only the DONE-cycle values are guaranteed.
- Width rules:
  - R is WIDTH+1 bits, so the trial subtraction cannot lose the borrow.
  - Remainder < divisor always holds for divisor != 0.
  - dividend < divisor yields quotient=0, remainder=dividend.
- Reset mid-operation: abort immediately to IDLE with all outputs 0; no done pulse.

Decomposition:
- Package divider_pkg holds:
  - the state enum typedef (IDLE, CALC, DONE);
  - localparam default WIDTH;
  - the divide-by-zero quotient constant (all ones).
- One sub-module, iteration_counter: loadable down-counter with en, load and zero flag.
  - Parameter SIZE=CNT_W.
  - Asynchronous active-high reset on rst.
  - Driven by the FSM: load in IDLE on start, en in CALC.
- Datapath (shift/trial-subtract/restore) and FSM live in the top module.

Test Plan:
- WIDTH=8, dividend=100, divisor=7, start one cycle -> busy next cycle; done in cycle 9; quotient=14, remainder=2, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0; then dividend=5, divisor=9 -> quotient=0, remainder=5; back-to-back issue accepted the cycle after IDLE returns.
- dividend=77, divisor=0 -> done in cycle 1; quotient=8'hFF, remainder=77, div_by_zero=1; next valid op clears div_by_zero.
- During 200/13, pulse start with 9/3 at cycle 4 -> ignored; done at cycle 9 with quotient=15, remainder=5.
- Assert rst at cycle 5 of a 200/13 op -> outputs 0 immediately, busy=0, no done pulse; fresh 50/6 then yields quotient=8, remainder=2.
- Randomised self-check, 1000 ops, WIDTH=8 and WIDTH=16 -> quotient*divisor+remainder==dividend and remainder<divisor for divisor!=0; done width exactly one cycle.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the shift/subtract divider.
//   - state_t            : controller states (IDLE, CALC, DONE)
//   - DEFAULT_WIDTH      : default operand width
//   - DBZ_QUOTIENT_ALL   : all-ones quotient returned on divide-by-zero.
//                          It is kept wide so any WIDTH can slice it.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [63:0] DBZ_QUOTIENT_ALL = '1;

endpackage

// File: rtl/iteration_counter.sv
// Loadable down-counter with zero flag, used to count divider iterations.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_load        : load i_load_value (has priority over i_en)
//   i_en          : decrement by one (saturates at zero)
//   i_load_value  : value loaded on i_load
//   o_count       : current count
//   o_zero        : high when the count is zero
module iteration_counter #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic            i_load,
  input  logic [SIZE-1:0] i_load_value,
  output logic [SIZE-1:0] o_count,
  output logic            o_zero
);

  logic [SIZE-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - SIZE'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/shift_sub_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : request, sampled only in IDLE
//   dividend/divisor: operands, captured when start is accepted
//   busy            : high in CALC and DONE
//   done            : one-cycle pulse, results valid and held afterwards
//   quotient        : result quotient (all ones on divide-by-zero)
//   remainder       : result remainder (dividend on divide-by-zero)
//   div_by_zero     : set with done when the captured divisor was zero
module shift_sub_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] ITER_COUNT = CNT_W'(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  // The partial remainder always stays below the divisor, so only its low
  // WIDTH bits are stored; the extra borrow bit exists only in the
  // WIDTH+1-bit shifted/trial values below.
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic             r_dbz;

  logic             w_cnt_load;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_zero;
  logic [WIDTH:0]   w_r_shift;
  logic [WIDTH:0]   w_trial;

  iteration_counter #(
    .SIZE(CNT_W)
  ) u_iteration_counter (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_cnt_en),
    .i_load      (w_cnt_load),
    .i_load_value(ITER_COUNT),
    .o_count     (w_cnt),
    .o_zero      (w_cnt_zero)
  );

  // {R,Q} shifted left by one, then trial subtraction of the divisor.
  // A set MSB on the trial means the subtraction borrowed: restore.
  assign w_r_shift = {r_r, r_q[WIDTH-1]};
  assign w_trial   = w_r_shift - {1'b0, r_d};

  always_comb begin
    w_state_next = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_cnt_load   = 1'b1;
          w_state_next = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        w_cnt_en = 1'b1;
        // Count of one means this edge runs the last iteration; the zero
        // check only guards against an unreachable stuck state.
        if ((w_cnt == CNT_W'(1)) || w_cnt_zero) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_d <= divisor;
            if (divisor == '0) begin
              r_q   <= DBZ_QUOTIENT_ALL[WIDTH-1:0];
              r_r   <= dividend;
              r_dbz <= 1'b1;
            end else begin
              r_q   <= dividend;
              r_r   <= '0;
              r_dbz <= 1'b0;
            end
          end
        end
        CALC: begin
          if (!w_trial[WIDTH]) begin
            r_r <= w_trial[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_r <= w_r_shift[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], 1'b0};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign quotient    = r_q;
  assign remainder   = r_r;
  assign div_by_zero = r_dbz;

endmodule
